ndro_pulse_sequencer: RTL

- Synchronous command-to-pulse driver placed directly upstream of ndro_cell; generates its on/off/sig input pulses.
- Accepts queued SET/RESET/READ commands and releases each as a pulse only once the cell's setup/hold spacing since the previous pulse is met.
- Tracks the cell's expected internal state and emits the expected out/dout values at the cell's output latency, for scoreboarding against the cell.

---
 rtl/ndro_pulse_sequencer_if.sv | 19 +
 rtl/ndro_pulse_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ndro_pulse_sequencer_if.sv
// Command handshake between a command source and the NDRO pulse sequencer.
// cmd_op: 01=ON, 10=OFF, 11=SIG, 00=NOP.
interface ndro_pulse_sequencer_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/ndro_pulse_sequencer.sv
// Queues ON/OFF/SIG commands and releases them as spaced pulses to an NDRO cell,
// while modelling the cell to emit expected out/dout strobes at cell latency.
module ndro_pulse_sequencer #(
    parameter int DEPTH       = 4,
    parameter int PULSE_W     = 2,
    parameter int GAP_ON_SIG  = 17,
    parameter int GAP_ON_OFF  = 16,
    parameter int GAP_OFF_SIG = 5,
    parameter int LAT_OUT     = 12,
    parameter int LAT_DOUT    = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ndro_pulse_sequencer_if.slave  cmd,
    output logic                   on,
    output logic                   off,
    output logic                   sig,
    output logic                   busy,
    output logic                   exp_out_valid,
    output logic                   exp_out,
    output logic                   exp_dout_valid,
    output logic                   exp_dout
);
    localparam int AW      = $clog2(DEPTH);
    localparam int PW_W    = $clog2(PULSE_W + 1);
    localparam int MIN_GAP = PULSE_W + 1;
    localparam int E_OS    = (GAP_ON_SIG > MIN_GAP) ? GAP_ON_SIG : MIN_GAP;
    localparam int E_OO    = (GAP_ON_OFF > MIN_GAP) ? GAP_ON_OFF : MIN_GAP;
    localparam int E_FS    = (GAP_OFF_SIG > MIN_GAP) ? GAP_OFF_SIG : MIN_GAP;
    localparam int MAX_A   = (E_OS > E_OO) ? E_OS : E_OO;
    localparam int MAX_GAP = (MAX_A > E_FS) ? MAX_A : E_FS;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ON   = 2'b01,
        OP_OFF  = 2'b10,
        OP_SIG  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PULSE
    } state_t;

    op_t           mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          push, pop, empty;
    op_t           head;

    state_t          state, state_n;
    op_t             cur_op, last_op;
    logic [7:0]      cnt;
    logic [PW_W-1:0] pw_cnt;
    logic            model;
    logic            fire, gap_ok;

    logic [LAT_OUT-1:0]  out_v, out_d;
    logic [LAT_DOUT-1:0] dout_v, dout_d;

    // Same-op pairs fall through to the minimum pulse-plus-one spacing.
    function automatic logic [8:0] eff_gap(op_t a, op_t b);
        logic [8:0] g;
        g = 9'(MIN_GAP);
        if (a == OP_NONE) begin
            g = '0;
        end else if (a != b) begin
            if (a != OP_OFF && b != OP_OFF)
                g = 9'(E_OS);
            else if (a != OP_SIG && b != OP_SIG)
                g = 9'(E_OO);
            else
                g = 9'(E_FS);
        end
        return g;
    endfunction

    assign empty         = (count == '0);
    assign head          = mem[rptr];
    assign cmd.cmd_ready = (count != FULL);
    assign push = cmd.cmd_valid && cmd.cmd_ready && (cmd.cmd_op != 2'b00);
    assign pop  = fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= OP_NONE;
        end else begin
            if (push) begin
                mem[wptr] <= op_t'(cmd.cmd_op);
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // cnt is registered, so cnt+1 here equals elapsed cycles at the next rise.
    assign gap_ok = ({1'b0, cnt} + 9'd1) >= eff_gap(last_op, head);

    always_comb begin
        state_n = state;
        fire    = 1'b0;
        unique case (state)
            S_IDLE, S_WAIT: begin
                if (empty) begin
                    state_n = S_IDLE;
                end else if (gap_ok) begin
                    state_n = S_PULSE;
                    fire    = 1'b1;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_PULSE: begin
                if (pw_cnt == PW_W'(PULSE_W - 1))
                    state_n = empty ? S_IDLE : S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_op  <= OP_NONE;
            last_op <= OP_NONE;
            cnt     <= 8'hff;
            pw_cnt  <= '0;
            model   <= 1'b0;
        end else begin
            state <= state_n;
            if (fire) begin
                cur_op  <= head;
                last_op <= head;
                cnt     <= '0;
                pw_cnt  <= '0;
                if (head == OP_ON)
                    model <= 1'b1;
                else if (head == OP_OFF)
                    model <= 1'b0;
            end else begin
                if (cnt != 8'hff)
                    cnt <= cnt + 8'd1;
                if (state == S_PULSE)
                    pw_cnt <= pw_cnt + 1'b1;
            end
        end
    end

    assign on   = (state == S_PULSE) && (cur_op == OP_ON);
    assign off  = (state == S_PULSE) && (cur_op == OP_OFF);
    assign sig  = (state == S_PULSE) && (cur_op == OP_SIG);
    assign busy = !empty || (state != S_IDLE) || (cnt < 8'(MAX_GAP));

    // Shift pipelines keep every in-flight sample; model is pre-update here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v          <= '0;
            out_d          <= '0;
            dout_v         <= '0;
            dout_d         <= '0;
            exp_out_valid  <= 1'b0;
            exp_out        <= 1'b0;
            exp_dout_valid <= 1'b0;
            exp_dout       <= 1'b0;
        end else begin
            out_v  <= (out_v << 1) | LAT_OUT'(fire && head == OP_SIG);
            out_d  <= (out_d << 1) | LAT_OUT'(model);
            dout_v <= (dout_v << 1) | LAT_DOUT'(fire && head == OP_OFF);
            dout_d <= (dout_d << 1) | LAT_DOUT'(model);
            exp_out_valid  <= out_v[LAT_OUT-1];
            exp_dout_valid <= dout_v[LAT_DOUT-1];
            if (out_v[LAT_OUT-1])
                exp_out <= out_d[LAT_OUT-1];
            if (dout_v[LAT_DOUT-1])
                exp_dout <= dout_d[LAT_DOUT-1];
        end
    end
endmodule
